alu_issue_ctrl: RTL and testbench

Initiator side of the ALU operand/control interface. It accepts decoded-instruction requests (ALUOp + funct + two operands) over a valid/ready handshake and translates them into the 4-bit ALU control code. It drives the registered ALU's a/b/control inputs, waits out the ALU's one-clock result latency, captures result/zero, and returns them over a valid/ready response channel. It sits between the decode stage and the ALU.

---
 rtl/alu_pkg.sv | 32 +++
 rtl/alu_ctrl_decode.sv | 32 +++
 rtl/alu_issue_ctrl.sv | 116 +++++++++++
 tb/tb_alu_issue_ctrl.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared ALU encodings: control codes, ALUOp/funct fields and the issue FSM states.
package alu_pkg;

  localparam int unsigned ALU_WIDTH = 48;

  localparam logic [3:0] ALU_AND = 4'h0;
  localparam logic [3:0] ALU_OR  = 4'h1;
  localparam logic [3:0] ALU_ADD = 4'h2;
  localparam logic [3:0] ALU_SUB = 4'h6;
  localparam logic [3:0] ALU_SLT = 4'h7;
  localparam logic [3:0] ALU_NOR = 4'hC;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;
  localparam logic [1:0] ALUOP_RSVD  = 2'b11;

  localparam logic [5:0] FUNCT_ADD = 6'b100000;
  localparam logic [5:0] FUNCT_SUB = 6'b100010;
  localparam logic [5:0] FUNCT_AND = 6'b100100;
  localparam logic [5:0] FUNCT_OR  = 6'b100101;
  localparam logic [5:0] FUNCT_SLT = 6'b101010;
  localparam logic [5:0] FUNCT_NOR = 6'b100111;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_CAPTURE,
    ST_RESP
  } state_t;

endpackage

// File: rtl/alu_ctrl_decode.sv
// Combinational {aluop, funct} -> 4-bit ALU control code plus illegal flag.
module alu_ctrl_decode
  import alu_pkg::*;
(
  input  logic [1:0] aluop,
  input  logic [5:0] funct,
  output logic [3:0] control,
  output logic       illegal
);

  always_comb begin
    control = ALU_AND;
    illegal = 1'b0;
    case (aluop)
      ALUOP_ADD: control = ALU_ADD;
      ALUOP_SUB: control = ALU_SUB;
      ALUOP_FUNCT: begin
        case (funct)
          FUNCT_ADD: control = ALU_ADD;
          FUNCT_SUB: control = ALU_SUB;
          FUNCT_AND: control = ALU_AND;
          FUNCT_OR:  control = ALU_OR;
          FUNCT_SLT: control = ALU_SLT;
          FUNCT_NOR: control = ALU_NOR;
          default:   illegal = 1'b1;
        endcase
      end
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/alu_issue_ctrl.sv
// Issues decoded requests to a registered ALU, waits out its latency and returns the result.
module alu_issue_ctrl
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = ALU_WIDTH,
  parameter int unsigned TAG_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [1:0]       req_aluop,
  input  logic [5:0]       req_funct,
  input  logic [WIDTH-1:0] req_opa,
  input  logic [WIDTH-1:0] req_opb,
  input  logic [TAG_W-1:0] req_tag,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [3:0]       alu_control,
  input  logic [WIDTH-1:0] alu_result,
  input  logic             alu_zero,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_result,
  output logic             rsp_zero,
  output logic             rsp_illegal,
  output logic [TAG_W-1:0] rsp_tag
);

  state_t     state, state_n;
  logic [3:0] dec_control;
  logic       dec_illegal;
  logic       ld_issue, ld_illegal, ld_capture, rsp_done;

  alu_ctrl_decode u_decode (
    .aluop   (req_aluop),
    .funct   (req_funct),
    .control (dec_control),
    .illegal (dec_illegal)
  );

  assign req_ready = (state == ST_IDLE) && rst_n;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_n;
  end

  always_comb begin
    state_n    = state;
    ld_issue   = 1'b0;
    ld_illegal = 1'b0;
    ld_capture = 1'b0;
    rsp_done   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (req_valid && req_ready) begin
          if (dec_illegal) begin
            ld_illegal = 1'b1;
            state_n    = ST_RESP;
          end else begin
            ld_issue = 1'b1;
            state_n  = ST_ISSUE;
          end
        end
      end
      ST_ISSUE: state_n = ST_CAPTURE;
      ST_CAPTURE: begin
        ld_capture = 1'b1;
        state_n    = ST_RESP;
      end
      ST_RESP: begin
        if (rsp_ready) begin
          rsp_done = 1'b1;
          state_n  = ST_IDLE;
        end
      end
      default: state_n = ST_IDLE;
    endcase
  end

  // Tag is captured straight into rsp_tag: it only changes on accept, when no response is pending.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_a       <= '0;
      alu_b       <= '0;
      alu_control <= ALU_AND;
      rsp_valid   <= 1'b0;
      rsp_result  <= '0;
      rsp_zero    <= 1'b0;
      rsp_illegal <= 1'b0;
      rsp_tag     <= '0;
    end else begin
      if (ld_issue || ld_illegal) rsp_tag <= req_tag;
      if (ld_issue) begin
        alu_a       <= req_opa;
        alu_b       <= req_opb;
        alu_control <= dec_control;
      end
      if (ld_illegal) begin
        rsp_result  <= '0;
        rsp_zero    <= 1'b0;
        rsp_illegal <= 1'b1;
        rsp_valid   <= 1'b1;
      end
      if (ld_capture) begin
        rsp_result  <= alu_result;
        rsp_zero    <= alu_zero;
        rsp_illegal <= 1'b0;
        rsp_valid   <= 1'b1;
      end
      if (rsp_done) rsp_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Scoreboard bench for alu_issue_ctrl driving a behavioural registered ALU.
module tb_alu_issue_ctrl;

  localparam int unsigned W = 48;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic [1:0]    req_aluop = '0;
  logic [5:0]    req_funct = '0;
  logic [W-1:0]  req_opa = '0;
  logic [W-1:0]  req_opb = '0;
  logic [3:0]    req_tag = '0;
  logic [W-1:0]  alu_a, alu_b;
  logic [3:0]    alu_control;
  logic [W-1:0]  alu_result;
  logic          alu_zero;
  logic          rsp_valid;
  logic          rsp_ready = 1'b1;
  logic [W-1:0]  rsp_result;
  logic          rsp_zero, rsp_illegal;
  logic [3:0]    rsp_tag;

  alu_issue_ctrl #(.WIDTH(W), .TAG_W(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_aluop(req_aluop), .req_funct(req_funct),
    .req_opa(req_opa), .req_opb(req_opb), .req_tag(req_tag),
    .alu_a(alu_a), .alu_b(alu_b), .alu_control(alu_control),
    .alu_result(alu_result), .alu_zero(alu_zero),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_result(rsp_result), .rsp_zero(rsp_zero),
    .rsp_illegal(rsp_illegal), .rsp_tag(rsp_tag)
  );

  always #5 clk = ~clk;

  // Behavioural ALU: unreset result register, combinational zero flag
  always @(posedge clk) begin
    case (alu_control)
      4'h0: alu_result <= alu_a & alu_b;
      4'h1: alu_result <= alu_a | alu_b;
      4'h2: alu_result <= alu_a + alu_b;
      4'h6: alu_result <= alu_a - alu_b;
      4'h7: alu_result <= ($signed(alu_a) < $signed(alu_b)) ? 48'd1 : 48'd0;
      4'hC: alu_result <= ~(alu_a | alu_b);
      default: alu_result <= '0;
    endcase
  end
  assign alu_zero = (alu_result == '0);

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [W-1:0] res;
    logic         zero;
    logic         ill;
    logic [3:0]   tag;
    logic [3:0]   ctrl;
    int           acc;
  } exp_t;

  exp_t sb[$];
  int n_chk = 0;
  int n_err = 0;

  function automatic void check(string name, logic [63:0] act, logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, exp, $time);
    end
  endfunction

  logic prev_v = 1'b0;
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) prev_v = 1'b0;
    else begin
      if (rsp_valid && !prev_v) begin
        if (sb.size() == 0) begin
          n_chk++;
          n_err++;
          $display("FAIL unexpected_rsp: got response tag %0h, required none", rsp_tag);
        end else begin
          e = sb.pop_front();
          check("rsp_result", 64'(rsp_result), 64'(e.res));
          check("rsp_zero", 64'(rsp_zero), 64'(e.zero));
          check("rsp_illegal", 64'(rsp_illegal), 64'(e.ill));
          check("rsp_tag", 64'(rsp_tag), 64'(e.tag));
          check("alu_control", 64'(alu_control), 64'(e.ctrl));
          check("latency", 64'(cyc), 64'(e.acc + (e.ill ? 0 : 2)));
        end
      end
      prev_v = rsp_valid;
    end
  end

  task automatic issue(input logic [1:0] op, input logic [5:0] fn, input logic [W-1:0] a,
                       input logic [W-1:0] b, input logic [3:0] tag, input logic [W-1:0] res,
                       input logic zero, input logic ill, input logic [3:0] ctrl);
    exp_t e;
    bit ok = 0;
    @(negedge clk);
    req_aluop = op; req_funct = fn; req_opa = a; req_opb = b; req_tag = tag;
    req_valid = 1'b1;
    for (int i = 0; i < 40; i++) begin
      if (req_ready) begin ok = 1; break; end
      @(negedge clk);
    end
    if (!ok) begin
      n_chk++;
      n_err++;
      $display("FAIL accept_timeout: got req_ready=0 for tag %0h, required 1", tag);
    end else begin
      e.res = res; e.zero = zero; e.ill = ill; e.tag = tag; e.ctrl = ctrl; e.acc = cyc + 1;
      sb.push_back(e);
    end
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  initial begin
    bit seen;
    repeat (2) @(negedge clk);
    check("rst_alu_a", 64'(alu_a), 64'h0);
    check("rst_alu_b", 64'(alu_b), 64'h0);
    check("rst_alu_control", 64'(alu_control), 64'h0);
    check("rst_rsp_valid", 64'(rsp_valid), 64'h0);
    check("rst_rsp_result", 64'(rsp_result), 64'h0);
    check("rst_rsp_illegal", 64'(rsp_illegal), 64'h0);
    check("rst_rsp_tag", 64'(rsp_tag), 64'h0);
    check("rst_req_ready", 64'(req_ready), 64'h0);
    rst_n = 1'b1;

    issue(2'b10, 6'b100000, 48'd7, 48'd5, 4'h3, 48'd12, 1'b0, 1'b0, 4'h2);
    issue(2'b01, 6'b000000, 48'h1234, 48'h1234, 4'h5, 48'd0, 1'b1, 1'b0, 4'h6);
    issue(2'b10, 6'b101010, 48'hFFFF_FFFF_FFFB, 48'd3, 4'h6, 48'd1, 1'b0, 1'b0, 4'h7);
    issue(2'b10, 6'b101010, 48'd3, 48'hFFFF_FFFF_FFFB, 4'h7, 48'd0, 1'b1, 1'b0, 4'h7);
    issue(2'b10, 6'b100111, 48'd0, 48'd0, 4'h8, 48'hFFFF_FFFF_FFFF, 1'b0, 1'b0, 4'hC);
    issue(2'b10, 6'b000000, 48'd9, 48'd9, 4'h9, 48'd0, 1'b0, 1'b1, 4'hC);
    issue(2'b10, 6'b100100, 48'hF0F0, 48'hFF00, 4'hA, 48'hF000, 1'b0, 1'b0, 4'h0);
    issue(2'b10, 6'b100101, 48'hF0F0, 48'h0F0F, 4'hA, 48'hFFFF, 1'b0, 1'b0, 4'h1);
    issue(2'b00, 6'b000000, 48'hFFFF_FFFF_FFFF, 48'd1, 4'hB, 48'd0, 1'b1, 1'b0, 4'h2);
    issue(2'b01, 6'b000000, 48'd0, 48'd1, 4'hC, 48'hFFFF_FFFF_FFFF, 1'b0, 1'b0, 4'h6);
    issue(2'b11, 6'b100000, 48'd1, 48'd1, 4'hD, 48'd0, 1'b0, 1'b1, 4'h6);

    // Back-pressure: response held for 5 cycles while a second request waits
    repeat (3) @(negedge clk);
    rsp_ready = 1'b0;
    issue(2'b00, 6'b000000, 48'h100, 48'h23, 4'hE, 48'h123, 1'b0, 1'b0, 4'h2);
    fork
      issue(2'b01, 6'b000000, 48'd10, 48'd3, 4'hF, 48'd7, 1'b0, 1'b0, 4'h6);
      begin
        seen = 0;
        for (int i = 0; i < 20; i++) begin
          if (rsp_valid) begin seen = 1; break; end
          @(negedge clk);
        end
        check("stall_rsp_seen", 64'(seen), 64'h1);
        for (int i = 0; i < 5; i++) begin
          @(negedge clk);
          check("stall_valid", 64'(rsp_valid), 64'h1);
          check("stall_result", 64'(rsp_result), 64'h123);
          check("stall_tag", 64'(rsp_tag), 64'hE);
          check("stall_req_ready", 64'(req_ready), 64'h0);
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        check("post_ack_req_ready", 64'(req_ready), 64'h1);
        check("post_ack_rsp_valid", 64'(rsp_valid), 64'h0);
      end
    join

    // Reset while the ALU result is being captured
    repeat (6) @(negedge clk);
    issue(2'b00, 6'b000000, 48'd1, 48'd1, 4'h1, 48'd2, 1'b0, 1'b0, 4'h2);
    @(posedge clk);
    #1 rst_n = 1'b0;
    sb.delete();
    #1;
    check("mid_rst_alu_a", 64'(alu_a), 64'h0);
    check("mid_rst_alu_control", 64'(alu_control), 64'h0);
    check("mid_rst_rsp_valid", 64'(rsp_valid), 64'h0);
    check("mid_rst_rsp_tag", 64'(rsp_tag), 64'h0);
    check("mid_rst_req_ready", 64'(req_ready), 64'h0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (6) @(negedge clk);
    check("post_rst_rsp_valid", 64'(rsp_valid), 64'h0);
    issue(2'b00, 6'b000000, 48'd2, 48'd2, 4'h2, 48'd4, 1'b0, 1'b0, 4'h2);

    for (int i = 0; i < 50 && sb.size() != 0; i++) @(negedge clk);
    if (sb.size() != 0) begin
      n_chk++;
      n_err++;
      $display("FAIL drain_timeout: got %0d responses outstanding, required 0", sb.size());
    end
    repeat (2) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_err);
    $finish;
  end

endmodule
